// File: rtl/sha_2_pkg.sv
// sha_const: SHA-2 round constants, initial values, state encoding and
// width-generic round functions shared by the sha_2 engine.
package sha_const;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } state_e;

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd,
        64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019,
        64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe,
        64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1,
        64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3,
        64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483,
        64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210,
        64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725,
        64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926,
        64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8,
        64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001,
        64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910,
        64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53,
        64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb,
        64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60,
        64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9,
        64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207,
        64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6,
        64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493,
        64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a,
        64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [511:0] IV384 = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507,
        64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511,
        64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };

    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    // Words travel zero-extended to 64 bits; callers truncate to WIDTH.
    function automatic logic [63:0] rotr(
        input logic [63:0] x,
        input int unsigned n,
        input int unsigned w
    );
        logic [63:0] r;
        case (w)
            32: r = {32'h0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
            default: r = (x >> n) | (x << (64 - n));
        endcase
        return r;
    endfunction

    function automatic logic [63:0] ch(
        input logic [63:0] x,
        input logic [63:0] y,
        input logic [63:0] z
    );
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [63:0] maj(
        input logic [63:0] x,
        input logic [63:0] y,
        input logic [63:0] z
    );
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [63:0] bsig0(
        input logic [63:0] x,
        input int unsigned w
    );
        logic [63:0] r;
        case (w)
            32: r = rotr(x, 2, w) ^ rotr(x, 13, w) ^ rotr(x, 22, w);
            default: r = rotr(x, 28, w) ^ rotr(x, 34, w) ^ rotr(x, 39, w);
        endcase
        return r;
    endfunction

    function automatic logic [63:0] bsig1(
        input logic [63:0] x,
        input int unsigned w
    );
        logic [63:0] r;
        case (w)
            32: r = rotr(x, 6, w) ^ rotr(x, 11, w) ^ rotr(x, 25, w);
            default: r = rotr(x, 14, w) ^ rotr(x, 18, w) ^ rotr(x, 41, w);
        endcase
        return r;
    endfunction

    function automatic logic [63:0] ssig0(
        input logic [63:0] x,
        input int unsigned w
    );
        logic [63:0] r;
        case (w)
            32: r = rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3);
            default: r = rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
        endcase
        return r;
    endfunction

    function automatic logic [63:0] ssig1(
        input logic [63:0] x,
        input int unsigned w
    );
        logic [63:0] r;
        case (w)
            32: r = rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
            default: r = rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
        endcase
        return r;
    endfunction

    function automatic logic [63:0] k_const(
        input logic [6:0] t,
        input int unsigned w
    );
        logic [63:0] r;
        case (w)
            32: r = {32'h0, K256[t[5:0]]};
            default: r = K512[t];
        endcase
        return r;
    endfunction

    function automatic logic [511:0] iv_const(
        input int unsigned w,
        input logic mode
    );
        logic [511:0] r;
        case (w)
            32: r = mode ? {256'h0, IV224} : {256'h0, IV256};
            default: r = mode ? IV384 : IV512;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha_2_if.sv
// Request/response bundle between the padding front end and the sha_2
// engine: one block per Enable, digest plus one-cycle Ready on completion.
interface sha_2_if #(
    parameter int WIDTH = 32
);
    logic [16*WIDTH-1:0] Data;
    logic [63:0]         Index;
    logic                Mode;
    logic                Enable;
    logic                Busy;
    logic [8*WIDTH-1:0]  Hash;
    logic                Ready;

    modport master (
        output Data, Index, Mode, Enable,
        input  Busy, Hash, Ready
    );

    modport slave (
        input  Data, Index, Mode, Enable,
        output Busy, Hash, Ready
    );
endinterface

// File: rtl/sha_2_schedule.sv
// Message schedule: 16-word sliding window, W[0] feeds the current round
// and the expanded word enters at W[15] on every shift.
module sha_2_schedule
    import sha_const::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                shift,
    input  logic [16*WIDTH-1:0] Data,
    output logic [WIDTH-1:0]    W0
);

    logic [WIDTH-1:0] w_q [16];
    logic [WIDTH-1:0] w_new;

    assign w_new = WIDTH'(ssig1(64'(w_q[14]), WIDTH))
                 + w_q[9]
                 + WIDTH'(ssig0(64'(w_q[1]), WIDTH))
                 + w_q[0];

    assign W0 = w_q[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= Data[i*WIDTH +: WIDTH];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                w_q[i] <= w_q[i+1];
            end
            w_q[15] <= w_new;
        end
    end

endmodule

// File: rtl/sha_2.sv
// SHA-2 compression engine, one round per clock; keeps the chaining
// value between blocks so multi-block messages need only Index.
module sha_2
    import sha_const::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    sha_2_if.slave  bus
);

    localparam int ROUNDS = (WIDTH == 32) ? 64 : 80;
    localparam int HW     = 8 * WIDTH;

    state_e state_q;
    state_e state_d;

    logic [6:0]       cnt_q;
    logic [HW-1:0]    hv_q;
    logic [HW-1:0]    wk_q;
    logic [HW-1:0]    hash_q;
    logic             ready_q;

    logic [HW-1:0]    start_h;
    logic [HW-1:0]    sum_h;
    logic [HW-1:0]    wk_d;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [WIDTH-1:0] w0, kt, t1, t2;
    logic             start;
    logic             shift;
    logic             last;

    assign {a, b, c, d, e, f, g, h} = wk_q;

    assign start = (state_q == IDLE) && bus.Enable;
    assign shift = (state_q == ROUND);
    assign last  = (cnt_q == 7'(ROUNDS - 1));

    sha_2_schedule #(
        .WIDTH(WIDTH)
    ) u_sched (
        .clk   (clk),
        .rst   (rst),
        .load  (start),
        .shift (shift),
        .Data  (bus.Data),
        .W0    (w0)
    );

    // The IV replaces the chaining value only on the first block.
    assign start_h = (bus.Index == 64'd1)
                   ? HW'(iv_const(WIDTH, bus.Mode))
                   : hv_q;

    assign kt = WIDTH'(k_const(cnt_q, WIDTH));

    assign t1 = h
              + WIDTH'(bsig1(64'(e), WIDTH))
              + WIDTH'(ch(64'(e), 64'(f), 64'(g)))
              + kt
              + w0;

    assign t2 = WIDTH'(bsig0(64'(a), WIDTH))
              + WIDTH'(maj(64'(a), 64'(b), 64'(c)));

    assign wk_d = {t1 + t2, a, b, c, d + t1, e, f, g};

    always_comb begin
        sum_h = '0;
        for (int k = 0; k < 8; k++) begin
            sum_h[k*WIDTH +: WIDTH] = hv_q[k*WIDTH +: WIDTH]
                                    + wk_q[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.Enable) state_d = ROUND;
            ROUND:   if (last) state_d = FINAL;
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            hv_q    <= '0;
            wk_q    <= '0;
            hash_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_q == FINAL);
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        hv_q  <= start_h;
                        wk_q  <= start_h;
                        cnt_q <= '0;
                    end
                end
                ROUND: begin
                    wk_q <= wk_d;
                    if (!last) cnt_q <= cnt_q + 7'd1;
                end
                FINAL: begin
                    hv_q   <= sum_h;
                    hash_q <= sum_h;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy  = (state_q != IDLE);
    assign bus.Ready = ready_q;
    assign bus.Hash  = hash_q;

endmodule

// File: tb/tb_sha_2.sv
// Directed-vector bench for sha_2 at WIDTH=32 and WIDTH=64 using the
// published FIPS 180 example digests.
module tb_sha_2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sha_2_if #(.WIDTH(32)) bus32 ();
    sha_2_if #(.WIDTH(64)) bus64 ();

    sha_2 #(.WIDTH(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    sha_2 #(.WIDTH(64)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64)
    );

    localparam logic [255:0] ABC256 = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };
    localparam logic [223:0] ABC224 = {
        32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
        32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7
    };
    localparam logic [255:0] TWO256 = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1
    };
    localparam logic [511:0] ABC512 = {
        64'hddaf35a193617aba, 64'hcc417349ae204131,
        64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
        64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
        64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f
    };

    logic [31:0] msg1 [16] = '{
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(
        input string       tag,
        input logic [511:0] got,
        input logic [511:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic start32(
        input logic [511:0] d,
        input logic [63:0]  idx,
        input logic         md
    );
        @(negedge clk);
        bus32.Data   = d;
        bus32.Index  = idx;
        bus32.Mode   = md;
        bus32.Enable = 1'b1;
        @(posedge clk);
        #1 bus32.Enable = 1'b0;
    endtask

    task automatic wait_ready32(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus32.Ready && n < 200);
    endtask

    logic [511:0]  abc32, blk1, blk2, junk;
    logic [1023:0] abc64;
    logic [255:0]  snap;
    int            n;
    int            pulses;

    initial begin
        abc32 = '0;
        abc32[31:0]    = 32'h61626380;
        abc32[511:480] = 32'h00000018;
        blk1 = '0;
        for (int i = 0; i < 16; i++) blk1[i*32 +: 32] = msg1[i];
        blk2 = '0;
        blk2[511:480] = 32'h000001c0;
        junk = {16{32'hdeadbeef}};
        abc64 = '0;
        abc64[63:0]     = 64'h6162638000000000;
        abc64[1023:960] = 64'h18;

        bus32.Data = '0; bus32.Index = '0;
        bus32.Mode = 1'b0; bus32.Enable = 1'b0;
        bus64.Data = '0; bus64.Index = '0;
        bus64.Mode = 1'b0; bus64.Enable = 1'b0;

        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy32", 512'(bus32.Busy), 512'd0);
        check("rst_ready32", 512'(bus32.Ready), 512'd0);
        check("rst_hash32", 512'(bus32.Hash), 512'd0);
        check("rst_busy64", 512'(bus64.Busy), 512'd0);
        check("rst_hash64", 512'(bus64.Hash), 512'd0);
        rst = 1'b1;

        start32(abc32, 64'd1, 1'b0);
        check("busy_run", 512'(bus32.Busy), 512'd1);
        wait_ready32(n);
        check("lat_abc256", 512'(n), 512'd65);
        check("abc256", 512'(bus32.Hash), 512'(ABC256));
        @(posedge clk);
        #1;
        check("ready_drop", 512'(bus32.Ready), 512'd0);
        check("idle_busy", 512'(bus32.Busy), 512'd0);

        start32(abc32, 64'd1, 1'b1);
        wait_ready32(n);
        check("lat_abc224", 512'(n), 512'd65);
        check("abc224", 512'(bus32.Hash[255:32]), 512'(ABC224));

        start32(blk1, 64'd1, 1'b0);
        wait_ready32(n);
        check("lat_blk1", 512'(n), 512'd65);
        start32(blk2, 64'd2, 1'b1);
        wait_ready32(n);
        check("lat_blk2", 512'(n), 512'd65);
        check("two_block", 512'(bus32.Hash), 512'(TWO256));

        start32(abc32, 64'd1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        bus32.Data   = junk;
        bus32.Index  = 64'd1;
        bus32.Mode   = 1'b1;
        bus32.Enable = 1'b1;
        check("busy_junk", 512'(bus32.Busy), 512'd1);
        @(posedge clk);
        #1;
        bus32.Enable = 1'b0;
        bus32.Data   = abc32;
        bus32.Mode   = 1'b0;
        pulses = 0;
        snap   = '0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus32.Ready) begin
                pulses++;
                snap = bus32.Hash;
            end
        end
        check("junk_pulses", 512'(pulses), 512'd1);
        check("junk_abc256", 512'(snap), 512'(ABC256));

        start32(abc32, 64'd1, 1'b0);
        repeat (30) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_busy", 512'(bus32.Busy), 512'd0);
        check("arst_ready", 512'(bus32.Ready), 512'd0);
        check("arst_hash", 512'(bus32.Hash), 512'd0);
        @(negedge clk);
        rst = 1'b1;
        start32(abc32, 64'd1, 1'b0);
        wait_ready32(n);
        check("lat_after_rst", 512'(n), 512'd65);
        check("abc_after_rst", 512'(bus32.Hash), 512'(ABC256));

        @(negedge clk);
        bus64.Data   = abc64;
        bus64.Index  = 64'd1;
        bus64.Mode   = 1'b0;
        bus64.Enable = 1'b1;
        @(posedge clk);
        #1 bus64.Enable = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus64.Ready && n < 200);
        check("lat_abc512", 512'(n), 512'd81);
        check("abc512", bus64.Hash, ABC512);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sha_2.md
Name: sha_2

Overview:
- Parametrised SHA-2 compression core; the successor to the team's fixed SHA-1 core.
- Word width is selectable: WIDTH=32 gives SHA-224/256 (64 rounds), WIDTH=64 gives SHA-384/512 (80 rounds).
- Processes one pre-padded 16-word block per request, one round per cycle, and keeps the chaining value internally for multi-block messages.
- Sits behind the padding/message-framing logic; it is the hash engine of the sha subsystem.

Parameters:
- WIDTH, 32, word width in bits; legal values are 32 or 64 only.
- ROUNDS, (WIDTH==32 ? 64 : 80), round count; derived, not user-overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- Data  in  16*WIDTH  padded block; word i = Data[i*WIDTH +: WIDTH]; word 0 is the first big-endian message word.
- Index  in  64  block number within the message; 1 = first block.
- Mode  in  1  0 = SHA-256/512 IV, 1 = SHA-224/384 IV; sampled only when Index==1.
- Enable  in  1  start request.
- Busy  out  1  high while a block is in flight.
- Hash  out  8*WIDTH  {H0..H7}, H0 in the MSBs; the consumer truncates for 224/384.
- Ready  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous, active-low.
- Reset values: state=IDLE, Busy=0, Ready=0, Hash=0, chaining H=0, round counter t=0, schedule buffer=0, working vars a..h=0.
- IDLE, Enable sampled 1 at edge E0:
  - Load schedule buffer W[0..15] from Data.
  - If Index==1: H = IV(WIDTH, Mode). Otherwise H = current chaining value.
  - a..h = that H.
  - t=0; go to ROUND.
- ROUND, edges E1..E_ROUNDS, one round per edge using W[0]:
  - T1 = h + S1(e) + CH(e,f,g) + K[t] + W[0]
  - T2 = S0(a) + MAJ(a,b,c)
  - h..a = g, f, e, d+T1, c, b, a, T1+T2
  - Schedule: W shifts down one; new W[15] = s1(W[14]) + W[9] + s0(W[1]) + W[0].
  - At t=ROUNDS-1 go to FINAL; otherwise t++.
- Rotate/shift constants:
  - WIDTH=32: S0 = 2,13,22; S1 = 6,11,25; s0 = 7,18,>>3; s1 = 17,19,>>10.
  - WIDTH=64: S0 = 28,34,39; S1 = 14,18,41; s0 = 1,8,>>7; s1 = 19,61,>>6.
- Arithmetic: all sums are modulo 2^WIDTH, with no carry-out.
- FINAL, edge E_ROUNDS+1:
  - H[i] += working var i; Hash <= new H; Ready <= 1; go to IDLE.
  - Ready drops at the next edge.
- Latency: Ready is high in the cycle after edge E_ROUNDS+1, i.e. ROUNDS+1 edges after the Enable sample. That is 65 edges for WIDTH=32 and 81 for WIDTH=64.
- Throughput: one block per ROUNDS+2 cycles. Enable may be asserted in the same cycle Ready is high; it is accepted because state is IDLE.
- Busy: high whenever state != IDLE, including FINAL.
- Hash: holds its value until the next FINAL; it is stable while Busy.
- Enable while Busy: ignored, with no side effects. Data, Index and Mode may change freely while Busy.
- Index != 1 with no prior block since reset: chains from H=0 (defined, not useful).
- Mode: latched at the first block; ignored on subsequent blocks.
- Reset asserted mid-block: immediate return to the reset values; no Ready pulse; the chaining value is lost.

Decomposition:
- Package sha_const, extended with:
  - K256 (64 x 32-bit) and K512 (80 x 64-bit) tables.
  - IV224, IV256, IV384, IV512.
  - State encoding IDLE, ROUND, FINAL.
- Round functions ROTR, CH, MAJ, S0, S1, s0, s1: package functions parametrised by WIDTH via case on width.
- Sub-module sha_2_schedule: 16-word shift buffer plus word expansion.
  - Ports: clk, rst, load, shift, Data in, W0 out.
  - Replaces the 80-entry precompute array.
- The top level holds the state machine, working variables and chaining registers.

Test Plan:
- WIDTH=32, Mode=0, Index=1, "abc" block (word0=0x61626380, word15=0x00000018, others 0) -> after 65 edges Ready=1 for 1 cycle, Hash=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- WIDTH=32, Mode=1, same block -> Hash[255:32]=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
- WIDTH=32, two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (Index=1 then 2; second Enable issued in the Ready cycle) -> final Hash=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; no idle gap needed.
- WIDTH=64, Mode=0, "abc" (word0=0x6162638000000000, word15=0x18) -> after 81 edges Hash=ddaf35a193617aba cc417349ae204131 12e6fa4e89a97ea2 0a9eeee64b55d39a 2192992a274fc1a8 36ba3c23a3feebbd 454d4423643ce80e 2a9ac94fa54ca49f.
- WIDTH=32, Enable pulsed at t=10 with garbage Data and Index=1 -> ignored; the "abc" digest is still correct; exactly one Ready pulse.
- WIDTH=32, rst low at t=30 -> Busy=0, Hash=0, Ready=0 immediately (asynchronous); a fresh "abc" block then yields the correct digest.
